// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if
//   Bundle between the eight requesters and the round-robin arbiter of the
//   shared 8:1 mux.
//   req      8  requester i wants mux input Di routed to out
//   grant    8  one-hot grant, all-zero when no owner
//   sel      3  mux select {S2,S1,S0}
//   valid    1  sel is stable and out carries D[sel]
//   timeout  1  one-cycle pulse when a grant is revoked by the hold limit
//   master: requester side.  slave: arbiter side.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       timeout;

  modport master (
    output req,
    input  grant,
    input  sel,
    input  valid,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output sel,
    output valid,
    output timeout
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin arbiter sharing the 8:1 mux datapath between 8 requesters.
//   A grant is held until its owner drops req, followed by one dead cycle
//   (break-before-make) before the next arbitration.
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of mux8_rr_arbiter_if (req in; grant/sel/valid/timeout out)
// Parameters
//   HOLD_MAX  maximum cycles one owner may hold the grant (timeout build only)
//   CNT_W     hold-counter width, 2**CNT_W must exceed HOLD_MAX
// Build option
//   MUX8_ARB_TIMEOUT_EN  when defined, ownership is bounded to HOLD_MAX cycles
//                        and timeout pulses on a forced release; otherwise
//                        timeout is tied low and ownership is unbounded.
//
// state   | meaning
// IDLE    | no owner; arbitrate among req starting at ptr
// GRANT   | owner = sel; hold until owner drops req (or hold limit)
// RELEASE | dead cycle between owners; sel frozen, valid low
module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  mux8_rr_arbiter_if.slave   bus
);

  if ((2 ** CNT_W) <= HOLD_MAX) begin : g_cfg_check
    $error("mux8_rr_arbiter: CNT_W too narrow for HOLD_MAX");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] grant_q, grant_nx;
  logic [2:0] sel_q, sel_nx;
  logic       valid_q, valid_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] win;
  logic       found;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             timeout_q, timeout_nx;
`endif

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr + 3'(k)]) begin
        win   = ptr + 3'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_q;
    sel_nx   = sel_q;
    valid_nx = valid_q;
    ptr_nx   = ptr;
`ifdef MUX8_ARB_TIMEOUT_EN
    cnt_nx     = cnt;
    timeout_nx = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        grant_nx = 8'h00;
        valid_nx = 1'b0;
        if (found) begin
          grant_nx = 8'h01 << win;
          sel_nx   = win;
          valid_nx = 1'b1;
          state_nx = GRANT;
`ifdef MUX8_ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          grant_nx = 8'h00;
          valid_nx = 1'b0;
          ptr_nx   = sel_q + 3'd1;
          state_nx = RELEASE;
        end
`ifdef MUX8_ARB_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          grant_nx   = 8'h00;
          valid_nx   = 1'b0;
          ptr_nx     = sel_q + 3'd1;
          timeout_nx = 1'b1;
          state_nx   = RELEASE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      RELEASE: begin
        grant_nx = 8'h00;
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        grant_nx = 8'h00;
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      ptr     <= 3'd0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      sel_q   <= sel_nx;
      valid_q <= valid_nx;
      ptr     <= ptr_nx;
    end
  end

`ifdef MUX8_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      timeout_q <= timeout_nx;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int HOLD_MAX = 16;

  logic clk;
  logic rst_n;

  mux8_rr_arbiter_if bus();

  mux8_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared 8:1 datapath driven from sel
  logic [7:0] d [8];
  logic [7:0] mux_out;
  assign mux_out = d[bus.sel];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model: owner index (-1 = none), dead-cycle flag, search pointer
  int m_owner, m_ptr, m_sel, m_held;
  bit m_dead, m_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0;
    m_dead = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    m_timeout = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % 8; m_owner = -1; m_dead = 1'b1;
      end else if (TO_EN && m_held == HOLD_MAX) begin
        m_ptr = (m_owner + 1) % 8; m_owner = -1; m_dead = 1'b1; m_timeout = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_sel   = m_owner;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk({tag, "_grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, "_sel"}, 32'(bus.sel), 32'(m_sel));
    chk({tag, "_valid"}, 32'(bus.valid), 32'(m_owner >= 0));
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'(m_timeout));
    chk({tag, "_inv_onehot"}, 32'($onehot0(bus.grant)), 32'd1);
    chk({tag, "_inv_valid"}, 32'(bus.valid), 32'(bus.grant != 8'h00));
    if (bus.valid) chk({tag, "_inv_gsel"}, 32'(bus.grant[bus.sel]), 32'd1);
    if (m_owner >= 0) chk({tag, "_mux"}, 32'(mux_out), 32'(d[m_owner]));
  endtask

  task automatic cycle(input logic [7:0] r, input string tag);
    bus.req = r;
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    @(posedge clk);
    model_step(r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int run_len, first_low, next_high, to_cnt;
  logic [7:0] rq;

  initial begin
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    for (int i = 0; i < 8; i++) d[i] = 8'(i);
    model_reset();

    // reset held with all requesting
    @(posedge clk); @(posedge clk); #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    cycle(8'hFF, "rst_first");
    chk("rst_first_grant", 32'(bus.grant), 32'h01);

    // single request
    do_reset();
    cycle(8'h10, "single");
    chk("single_grant", 32'(bus.grant), 32'h10);
    chk("single_sel", 32'(bus.sel), 32'd4);
    cycle(8'h00, "single_drop");
    chk("single_drop_valid", 32'(bus.valid), 32'd0);
    cycle(8'h00, "single_rel");
    cycle(8'h00, "single_idle");

    // round robin with all requesting, 3 cycles per owner then a 1-cycle drop
    do_reset();
    for (int o = 0; o < 9; o++) begin
      cycle(8'hFF, "rr_arb");
      chk("rr_sel", 32'(bus.sel), 32'(o % 8));
      chk("rr_valid", 32'(bus.valid), 32'd1);
      cycle(8'hFF, "rr_hold");
      cycle(8'hFF, "rr_hold");
      cycle(8'hFF & ~(8'h01 << (o % 8)), "rr_drop");
      chk("rr_gap1", 32'(bus.valid), 32'd0);
      cycle(8'hFF, "rr_dead");
      chk("rr_gap2", 32'(bus.valid), 32'd0);
    end

    // wrap: owner 6 releases so ptr=7, then 7 beats 0
    do_reset();
    cycle(8'h40, "wrap_6");
    chk("wrap_sel6", 32'(bus.sel), 32'd6);
    cycle(8'h00, "wrap_drop6");
    cycle(8'h00, "wrap_dead");
    cycle(8'h81, "wrap_7");
    chk("wrap_sel7", 32'(bus.sel), 32'd7);
    cycle(8'h81, "wrap_hold7");
    cycle(8'h01, "wrap_drop7");
    cycle(8'h01, "wrap_dead7");
    cycle(8'h01, "wrap_0");
    chk("wrap_sel0", 32'(bus.sel), 32'd0);

    // async reset in the middle of a grant
    do_reset();
    cycle(8'h20, "areset_own");
    chk("areset_sel5", 32'(bus.sel), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset_grant", 32'(bus.grant), 32'h0);
    chk("areset_valid", 32'(bus.valid), 32'h0);
    chk("areset_sel", 32'(bus.sel), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    cycle(8'h04, "areset_after");
    chk("areset_sel2", 32'(bus.sel), 32'd2);

    // hold limit (or unbounded hold when the limit is not built)
    do_reset();
    run_len = 0; first_low = 0; next_high = 0; to_cnt = 0;
    for (int i = 1; i <= 120; i++) begin
      cycle(8'h08, "hold");
      if (bus.valid && first_low == 0) run_len++;
      if (!bus.valid && first_low == 0) first_low = i;
      if (bus.valid && first_low != 0 && next_high == 0) next_high = i;
      if (i <= 20 && bus.timeout) to_cnt++;
    end
    chk("hold_run_len", 32'(run_len), TO_EN ? 32'd16 : 32'd120);
    chk("hold_timeouts", 32'(to_cnt), TO_EN ? 32'd1 : 32'd0);
    chk("hold_first_low", 32'(first_low), TO_EN ? 32'd17 : 32'd0);
    chk("hold_regrant", 32'(next_high), TO_EN ? 32'd19 : 32'd0);

    // randomized traffic against the model
    do_reset();
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      cycle(rq, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
